mano_mem_arbiter: RTL

Two-port memory arbiter that shares the single Mano main memory between the CPU core (driven by the control path's `cs_mem_rd`/`cs_mem_wr`) and a DMA/loader port. It grants one requester at a time, latches the granted request's address and write data, and drives the memory strobes for a fixed access latency. It returns read data plus a one-cycle `ready` completion pulse to the granted requester. The block sits between `mano_core` and the memory model and adds the wait-state handshake the core uses to stall.

---
 rtl/mano_mem_arbiter_if.sv | 45 ++++
 rtl/mano_mem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mano_mem_arbiter_if.sv
// Bus bundle for mano_mem_arbiter: CPU port, DMA port, memory side, status.
// master = arbiter side, slave = requesters plus memory model.
interface mano_mem_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 16
);
   logic          cpu_rd;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ready;
   logic          dma_rd;
   logic          dma_wr;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic [DW-1:0] dma_rdata;
   logic          dma_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          owner;
   logic          busy;
   logic          err;

   modport master (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      input  dma_rd, dma_wr, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
      output mem_addr, mem_wdata, mem_rd, mem_wr,
      output owner, busy, err
   );

   modport slave (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      output dma_rd, dma_wr, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
      input  mem_addr, mem_wdata, mem_rd, mem_wr,
      input  owner, busy, err
   );
endinterface

// File: rtl/mano_mem_arbiter.sv
// Two-port (CPU/DMA) arbiter for the shared Mano main memory.
// Define MANO_ARB_RR_EN for round-robin; default is fixed CPU priority.
module mano_mem_arbiter #(
   parameter int AW      = 12,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input logic                mclk,
   input logic                mrst,
   mano_mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t        state;
   state_t        state_d;
   logic [3:0]    cnt;
   logic          owner_q;
   logic          op_wr;
   logic          err_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] cpu_rdata_q;
   logic [DW-1:0] dma_rdata_q;
   logic          cpu_req;
   logic          dma_req;
   logic          grant;
   logic          grant_dma;
   logic          last;

   assign cpu_req = bus.cpu_rd | bus.cpu_wr;
   assign dma_req = bus.dma_rd | bus.dma_wr;
   assign grant   = cpu_req | dma_req;
   assign last    = (cnt == 4'd0);

`ifdef MANO_ARB_RR_EN
   // On contention, the side that did not own the last grant wins.
   assign grant_dma = dma_req & (~cpu_req | ~owner_q);
`else
   assign grant_dma = dma_req & ~cpu_req;
`endif

   always_ff @(posedge mclk or negedge mrst) begin
      if (!mrst) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (grant) state_d = ACCESS;
         ACCESS:  if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge mrst) begin
      if (!mrst) begin
         cnt         <= 4'd0;
         owner_q     <= 1'b1;
         op_wr       <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else if (state == IDLE && grant) begin
         owner_q <= grant_dma;
         cnt     <= LAT_M1;
         // rd together with wr is serviced as a write and flagged.
         if (grant_dma) begin
            addr_q  <= bus.dma_addr;
            wdata_q <= bus.dma_wdata;
            op_wr   <= bus.dma_wr;
            if (bus.dma_rd && bus.dma_wr) err_q <= 1'b1;
         end else begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            op_wr   <= bus.cpu_wr;
            if (bus.cpu_rd && bus.cpu_wr) err_q <= 1'b1;
         end
      end else if (state == ACCESS) begin
         if (!last) begin
            cnt <= cnt - 4'd1;
         end else if (!op_wr) begin
            if (owner_q) dma_rdata_q <= bus.mem_rdata;
            else         cpu_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_rd    = (state == ACCESS) & ~op_wr;
   assign bus.mem_wr    = (state == ACCESS) & op_wr;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.cpu_ready = (state == DONE) & ~owner_q;
   assign bus.dma_ready = (state == DONE) & owner_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = (state != IDLE);
   assign bus.err       = err_q;
endmodule
